cpu_mem_arbiter: RTL

- Sits directly downstream of the cpu top level.
- Merges the cpu's instruction-memory port and data-memory port onto one shared memory-side port, which feeds the cache/physical memory.
- Serves one transaction at a time. Request fields are registered at grant; responses are routed back to the owning requester.
- Data port has fixed priority over instruction port, so a pending load/store is never starved by fetch.

---
 rtl/cpu_mem_arbiter_pkg.sv | 36 +++
 rtl/cpu_mem_arbiter_req_reg.sv | 59 +++++
 rtl/cpu_mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the cpu memory arbiter: word widths and the FSM/port enums.
// Also provides the grant-selection helper used by cpu_mem_arbiter.
package rv32i_types;

  localparam int WORD_WIDTH = 32;
  localparam int BYTE_WIDTH = 8;

  typedef logic [WORD_WIDTH-1:0] rv32i_word;

endpackage : rv32i_types

package arbiter_types;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_INST = 2'd1,
    SERVE_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } arb_port_t;

  // Data wins unless both request and the caller asks to favour inst this time.
  // With no request at all the result is irrelevant; the caller gates it.
  function automatic arb_port_t pick_winner(input logic inst_req,
                                            input logic data_req,
                                            input logic prefer_inst);
    if (data_req && !(inst_req && prefer_inst)) begin
      return PORT_DATA;
    end
    return PORT_INST;
  endfunction

endpackage : arbiter_types

// File: rtl/cpu_mem_arbiter_req_reg.sv
// arb_req_reg: holds the request fields presented on the shared memory port.
// Loaded at grant, read/write cleared on completion, zeroed by synchronous active-low reset.
module arb_req_reg #(
  parameter int WIDTH    = 32,
  parameter int BE_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic [WIDTH-1:0]    address_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [BE_WIDTH-1:0] byte_enable_i,
  input  logic [WIDTH-1:0]    wdata_i,
  output logic [WIDTH-1:0]    address_o,
  output logic                read_o,
  output logic                write_o,
  output logic [BE_WIDTH-1:0] byte_enable_o,
  output logic [WIDTH-1:0]    wdata_o
);

  logic [WIDTH-1:0]    address_q;
  logic                read_q;
  logic                write_q;
  logic [BE_WIDTH-1:0] byte_enable_q;
  logic [WIDTH-1:0]    wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  // NOTE: the data fields are reset too, not only the strobes, so the shared
  // port never shows a stale address after a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      address_q     <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      byte_enable_q <= '0;
      wdata_q       <= '0;
    end else if (load_i) begin
      address_q     <= address_i;
      read_q        <= read_i;
      write_q       <= write_i;
      byte_enable_q <= byte_enable_i;
      wdata_q       <= wdata_i;
    end else if (clear_i) begin
      // Address/data/byte-enable stay put; only the strobes drop.
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end
  end

  assign address_o     = address_q;
  assign read_o        = read_q;
  assign write_o       = write_q;
  assign byte_enable_o = byte_enable_q;
  assign wdata_o       = wdata_q;

endmodule : arb_req_reg

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges the cpu instruction and data memory ports onto one shared port.
// Fixed data priority by default; define ARB_ROUND_ROBIN_EN for alternating grants on contention.
module cpu_mem_arbiter
  import rv32i_types::*;
  import arbiter_types::*;
#(
  parameter int WIDTH    = WORD_WIDTH,
  parameter int BE_WIDTH = WIDTH / BYTE_WIDTH
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [WIDTH-1:0]    inst_mem_address,
  input  logic                inst_mem_read,
  input  logic                inst_mem_write,
  input  logic [BE_WIDTH-1:0] inst_mem_byte_enable,
  input  logic [WIDTH-1:0]    inst_mem_wdata,
  output logic [WIDTH-1:0]    inst_mem_rdata,
  output logic                inst_mem_resp,

  input  logic [WIDTH-1:0]    data_mem_address,
  input  logic                data_mem_read,
  input  logic                data_mem_write,
  input  logic [BE_WIDTH-1:0] data_mem_byte_enable,
  input  logic [WIDTH-1:0]    data_mem_wdata,
  output logic [WIDTH-1:0]    data_mem_rdata,
  output logic                data_mem_resp,

  output logic [WIDTH-1:0]    mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [BE_WIDTH-1:0] mem_byte_enable,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  input  logic                mem_resp
);

  arb_state_t state_q, state_d;
  arb_port_t  winner;

  logic                inst_req;
  logic                data_req;
  logic                grant;
  logic                clear;
  logic [WIDTH-1:0]    sel_address;
  logic                sel_read;
  logic                sel_write;
  logic [BE_WIDTH-1:0] sel_byte_enable;
  logic [WIDTH-1:0]    sel_wdata;

  assign inst_req = inst_mem_read | inst_mem_write;
  assign data_req = data_mem_read | data_mem_write;
  assign grant    = (state_q == IDLE) && (inst_req || data_req);
  assign clear    = (state_q != IDLE) && mem_resp;

`ifdef ARB_ROUND_ROBIN_EN
  arb_port_t last_grant_q, last_grant_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= PORT_INST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_d = grant ? winner : last_grant_q;
  assign winner       = pick_winner(inst_req, data_req, last_grant_q == PORT_DATA);
`else
  assign winner = pick_winner(inst_req, data_req, 1'b0);
`endif

  // Write beats read when a requester raises both.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_address     = inst_mem_address;
    sel_read        = inst_mem_read & ~inst_mem_write;
    sel_write       = inst_mem_write;
    sel_byte_enable = inst_mem_byte_enable;
    sel_wdata       = inst_mem_wdata;
    if (winner == PORT_DATA) begin
      sel_address     = data_mem_address;
      sel_read        = data_mem_read & ~data_mem_write;
      sel_write       = data_mem_write;
      sel_byte_enable = data_mem_byte_enable;
      sel_wdata       = data_mem_wdata;
    end
  end

  arb_req_reg #(
    .WIDTH    (WIDTH),
    .BE_WIDTH (BE_WIDTH)
  ) u_req_reg (
    .clk           (clk),
    .rst_n         (rst),
    .load_i        (grant),
    .clear_i       (clear),
    .address_i     (sel_address),
    .read_i        (sel_read),
    .write_i       (sel_write),
    .byte_enable_i (sel_byte_enable),
    .wdata_i       (sel_wdata),
    .address_o     (mem_address),
    .read_o        (mem_read),
    .write_o       (mem_write),
    .byte_enable_o (mem_byte_enable),
    .wdata_o       (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = (winner == PORT_DATA) ? SERVE_DATA : SERVE_INST;
        end
      end
      SERVE_INST, SERVE_DATA: begin
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the owner sees mem_resp/mem_rdata; a response arriving in IDLE goes nowhere.
  always_comb begin
    inst_mem_resp  = 1'b0;
    inst_mem_rdata = '0;
    data_mem_resp  = 1'b0;
    data_mem_rdata = '0;
    unique case (state_q)
      SERVE_INST: begin
        inst_mem_resp  = mem_resp;
        inst_mem_rdata = mem_rdata;
      end
      SERVE_DATA: begin
        data_mem_resp  = mem_resp;
        data_mem_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule : cpu_mem_arbiter
